decode_queue: RTL and testbench
===============================

# decode_queue

Circular buffer between the decoder and the rename stage. It accepts up to `INPORT_NUM` decoded micro-ops (`decinfo_t`) per cycle and compacts non-contiguous valid lanes into program order. It presents the oldest `OUTPORT_NUM` entries to rename with an all-or-nothing dequeue handshake. It decouples decode from rename back-pressure and is cleared on pipeline squash.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, ≥ 2·max(`INPORT_NUM`,`OUTPORT_NUM`).
- `INPORT_NUM`, 4: decode lanes per cycle.
- `OUTPORT_NUM`, 4: rename lanes per cycle.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `i_squash_vld`  in  1  flush all entries (backend redirect).
- `o_can_enq`  out  1  free entries ≥ `INPORT_NUM`.
- `i_enq_req`  in  1  decoder presents a group this cycle.
- `i_enq_vld`  in  `INPORT_NUM`  per-lane valid; any pattern allowed, lane 0 oldest.
- `i_decinfo`  in  `INPORT_NUM` × `decinfo_t`  per-lane payload.
- `o_deq_vld`  out  `OUTPORT_NUM`  output lane k holds a valid entry.
- `o_decinfo`  out  `OUTPORT_NUM` × `decinfo_t`  oldest entries, lane 0 oldest.
- `i_deq_ready`  in  1  rename consumes every lane with `o_deq_vld` set.
- `o_count`  out  $clog2(`DEPTH`)+1  occupied entries.

## Operation
- State: `DEPTH` × `decinfo_t` storage, `head`, `tail` ($clog2(`DEPTH`) bits, wrapping modulo `DEPTH`), and `count`.
- Enqueue fires when `i_enq_req & o_can_enq & !i_squash_vld`.
  - n = popcount(`i_enq_vld`).
  - The j-th set lane (counted from lane 0) writes `buf[(tail+j)%DEPTH]`.
  - `tail += n`.
  - n = 0 is legal and is a no-op.
- `i_enq_req` while `o_can_enq`=0: the group is dropped. The decoder must hold. Assertion: never enqueue when `o_can_enq`=0.
- Output view:
  - `o_deq_vld[k] = (k < count)`.
  - `o_decinfo[k] = buf[(head+k)%DEPTH]`.
  - Lanes with `o_deq_vld[k]`=0 carry don't-care data.
- Dequeue fires when `i_deq_ready & !i_squash_vld`.
  - m = min(`count`, `OUTPORT_NUM`).
  - `head += m`.
  - `i_deq_ready` with `count`=0 is a no-op.
- Count update: `count_next = count + n_fired − m_fired`. Enqueue and dequeue in the same cycle are both applied.
- Squash: `head`=`tail`=`count`=0 next edge. Same-cycle enqueue and dequeue are ignored. Storage contents are not cleared.
- `o_can_enq = (DEPTH − count) ≥ INPORT_NUM`. It depends on registered `count` only, with no combinational path from any input.
- `o_count` = registered `count`.
- Payload fields (`pc`, `imm20`, `csr_en`, `csr_idx`, `rd_wen`, `rd`, `rs1`, `rs2`, `fu_type`, `micOp_type`) pass through unmodified.

## Timing
- Reset values (asynchronous, immediate):
  - `head`=`tail`=`count`=0.
  - `o_deq_vld`=0.
  - `o_can_enq`=1.
  - `o_count`=0.
  - Storage is not reset.
- Latency: an entry enqueued at edge t appears on `o_decinfo` in the cycle after edge t. There is no enqueue-to-dequeue bypass.
- Throughput: `INPORT_NUM` in and `OUTPORT_NUM` out per cycle, sustained.
- Full / conservative full:
  - `o_can_enq` drops once free < `INPORT_NUM`, even when the incoming popcount would fit.
  - A same-cycle dequeue does not raise `o_can_enq` within that cycle. The change is visible the next cycle.
- Empty: all `o_deq_vld`=0; `i_deq_ready` is ignored.
- Wrap-around:
  - Writes and reads crossing index `DEPTH−1`→0 stay contiguous in order.
  - `count` reaches exactly `DEPTH` when full; pointers are equal at both full and empty, and `count` disambiguates.
- Reset asserted mid-operation: state clears asynchronously. The first enqueue is accepted on the first edge after deassertion.
- `i_squash_vld` has priority over enqueue and dequeue. The cycle after a squash shows empty outputs and `o_can_enq`=1.

## Test plan
- Reset, then enqueue mask 4'b1111 with pc 0x100/104/108/10C, `i_deq_ready`=0 → next cycle `o_deq_vld`=4'b1111, lane0 pc=0x100, lane3 pc=0x10C, `o_count`=4.
- Compaction: enqueue mask 4'b1010 with lane1 pc=0x200 and lane3 pc=0x208 into an empty queue → `o_deq_vld`=4'b0011, lane0 pc=0x200, lane1 pc=0x208, `o_count`=2.
- Fill: enqueue 4 per cycle with `i_deq_ready`=0 → after 3 groups `o_count`=12 and `o_can_enq`=1; after the 4th group `o_count`=16 and `o_can_enq`=0. `i_enq_req` while full leaves `o_count`=16.
- Wrap-around: run 10 cycles of concurrent 4-in/4-out with incrementing pc → output pc sequence is strictly +4 in order with no gaps or duplicates, and `o_count` stays at 4.
- Squash: at `o_count`=9, assert `i_squash_vld` together with `i_enq_req` and `i_deq_ready` → next cycle `o_count`=0, `o_deq_vld`=0, `o_can_enq`=1.
- Partial dequeue and mid-operation reset: at `o_count`=2 assert `i_deq_ready` → `o_count`=0. Then enqueue 4 and pulse `rst` between edges → `o_count`=0 immediately, and an enqueue on the first edge after release gives `o_count`=4.

Source files
------------

// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// decode_queue_pkg / decode_queue_if
//
// Purpose:
//   decode_queue_pkg holds the decoded micro-op payload type (decinfo_t) that
//   is shared by decode, the decode queue and rename.
//   decode_queue_if bundles the enqueue, dequeue and squash signals that sit
//   between the decoder/rename side and the decode queue.
//
// Interface signals:
//   i_squash_vld  1                       flush all entries
//   o_can_enq     1                       at least INPORT_NUM free entries
//   i_enq_req     1                       decoder presents a group
//   i_enq_vld     INPORT_NUM              per-lane valid, lane 0 oldest
//   i_decinfo     INPORT_NUM x decinfo_t  per-lane payload
//   o_deq_vld     OUTPORT_NUM             output lane holds a valid entry
//   o_decinfo     OUTPORT_NUM x decinfo_t oldest entries, lane 0 oldest
//   i_deq_ready   1                       rename takes every valid lane
//   o_count       CNT_W                   occupied entries
//
// Modports:
//   master : decoder / rename side (drives i_*, observes o_*)
//   slave  : the queue itself      (drives o_*, observes i_*)
// -----------------------------------------------------------------------------
package decode_queue_pkg;

    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_LSU = 3'd3,
        FU_BRU = 3'd4,
        FU_CSR = 3'd5
    } fu_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [19:0] imm20;
        logic        csr_en;
        logic [11:0] csr_idx;
        logic        rd_wen;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        fu_type_e    fu_type;
        logic [4:0]  micOp_type;
    } decinfo_t;

endpackage

interface decode_queue_if #(
    parameter int INPORT_NUM  = 4,
    parameter int OUTPORT_NUM = 4,
    parameter int CNT_W       = 5
);
    import decode_queue_pkg::*;

    logic                              i_squash_vld;
    logic                              o_can_enq;
    logic                              i_enq_req;
    logic [INPORT_NUM-1:0]             i_enq_vld;
    decinfo_t [INPORT_NUM-1:0]         i_decinfo;
    logic [OUTPORT_NUM-1:0]            o_deq_vld;
    decinfo_t [OUTPORT_NUM-1:0]        o_decinfo;
    logic                              i_deq_ready;
    logic [CNT_W-1:0]                  o_count;

    modport master (
        output i_squash_vld, i_enq_req, i_enq_vld, i_decinfo, i_deq_ready,
        input  o_can_enq, o_deq_vld, o_decinfo, o_count
    );

    modport slave (
        input  i_squash_vld, i_enq_req, i_enq_vld, i_decinfo, i_deq_ready,
        output o_can_enq, o_deq_vld, o_decinfo, o_count
    );

endinterface

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//
// Purpose:
//   Circular buffer between decode and rename. Accepts up to INPORT_NUM
//   micro-ops per cycle, compacting sparse valid lanes into program order,
//   and presents the oldest OUTPORT_NUM entries to rename with an
//   all-or-nothing dequeue. A squash empties the queue on the next edge.
//
// Ports:
//   clk  in  clock, all state updates on the rising edge
//   rst  in  asynchronous, active-high reset
//   dq   decode_queue_if.slave  enqueue / dequeue / squash bundle
// -----------------------------------------------------------------------------
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int INPORT_NUM  = 4,
    parameter int OUTPORT_NUM = 4
) (
    input  logic          clk,
    input  logic          rst,
    decode_queue_if.slave dq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    decinfo_t         mem_q [DEPTH];

    logic             enq_fire;
    logic             deq_fire;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] deq_m;
    logic [PTR_W-1:0] wr_idx [INPORT_NUM];

    // Conservative full: based on registered count only, so a same-cycle
    // dequeue never opens the door for an enqueue in that cycle.
    assign dq.o_can_enq = (CNT_W'(DEPTH) - count_q) >= CNT_W'(INPORT_NUM);
    assign dq.o_count   = count_q;

    assign enq_fire = dq.i_enq_req & dq.o_can_enq & ~dq.i_squash_vld;
    assign deq_fire = dq.i_deq_ready & ~dq.i_squash_vld;
    assign deq_m    = (count_q > CNT_W'(OUTPORT_NUM)) ? CNT_W'(OUTPORT_NUM) : count_q;

    // Compaction: each valid lane writes at tail plus the number of valid
    // lanes below it, so sparse groups land contiguously in program order.
    // NOTE: blocking assignments here are deliberate -- enq_n is a running
    // prefix sum that later loop iterations must see updated.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < INPORT_NUM; i++) begin
            wr_idx[i] = tail_q + enq_n[PTR_W-1:0];
            if (dq.i_enq_vld[i]) begin
                enq_n = enq_n + CNT_W'(1);
            end
        end
    end

    // Pointer / count next state; squash overrides both enqueue and dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (dq.i_squash_vld) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = tail_q + enq_n[PTR_W-1:0];
            end
            if (deq_fire) begin
                head_d = head_q + deq_m[PTR_W-1:0];
            end
            count_d = count_q + (enq_fire ? enq_n : '0) - (deq_fire ? deq_m : '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by count, so clearing
    // the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INPORT_NUM; i++) begin
            if (enq_fire && dq.i_enq_vld[i]) begin
                mem_q[wr_idx[i]] <= dq.i_decinfo[i];
            end
        end
    end

    // Output view: oldest entries starting at head; no enqueue bypass.
    always_comb begin
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            dq.o_deq_vld[k] = CNT_W'(k) < count_q;
            dq.o_decinfo[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    a_no_enq_when_full: assert property (
        @(posedge clk) disable iff (rst) enq_fire |-> dq.o_can_enq
    );

    a_count_in_range: assert property (
        @(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH)
    );

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
//
// Purpose:
//   Directed self-checking bench for decode_queue: reset values, full groups,
//   lane compaction, fill / conservative full, wrap-around streaming, squash,
//   partial dequeue and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH       = 16;
    localparam int INPORT_NUM  = 4;
    localparam int OUTPORT_NUM = 4;
    localparam int CNT_W       = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    decode_queue_if #(
        .INPORT_NUM (INPORT_NUM),
        .OUTPORT_NUM(OUTPORT_NUM),
        .CNT_W      (CNT_W)
    ) dq ();

    decode_queue #(
        .DEPTH      (DEPTH),
        .INPORT_NUM (INPORT_NUM),
        .OUTPORT_NUM(OUTPORT_NUM)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .dq (dq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Payload derived from pc so every field carries distinct, checkable bits.
    function automatic decinfo_t make_info(input logic [31:0] pc);
        decinfo_t d;
        d.pc         = pc;
        d.imm20      = pc[19:0] ^ 20'hABCDE;
        d.csr_en     = pc[2];
        d.csr_idx    = pc[13:2];
        d.rd_wen     = 1'b1;
        d.rd         = pc[6:2];
        d.rs1        = pc[7:3];
        d.rs2        = pc[8:4];
        d.fu_type    = FU_LSU;
        d.micOp_type = pc[6:2] ^ 5'h15;
        return d;
    endfunction

    // Lane l gets pc = base + 4*l; mask selects which lanes are valid.
    task automatic set_group(input logic req, input logic [3:0] mask, input logic [31:0] base);
        dq.i_enq_req = req;
        dq.i_enq_vld = mask;
        for (int l = 0; l < INPORT_NUM; l++) begin
            dq.i_decinfo[l] = make_info(base + 32'(4 * l));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_head;
    logic [31:0] next_in;

    initial begin
        rst             = 1'b1;
        dq.i_squash_vld = 1'b0;
        dq.i_deq_ready  = 1'b0;
        set_group(1'b0, 4'b0000, 32'h0);

        // Reset values
        step();
        step();
        check("rst_count",   dq.o_count,   0);
        check("rst_deq_vld", dq.o_deq_vld, 0);
        check("rst_can_enq", dq.o_can_enq, 1);
        rst = 1'b0;

        // Full group of four
        set_group(1'b1, 4'b1111, 32'h100);
        step();
        check("grp_deq_vld", dq.o_deq_vld,       4'b1111);
        check("grp_l0_pc",   dq.o_decinfo[0].pc, 32'h100);
        check("grp_l3_pc",   dq.o_decinfo[3].pc, 32'h10C);
        check("grp_l2_info", dq.o_decinfo[2],    make_info(32'h108));
        check("grp_count",   dq.o_count,         4);

        // Drain, then sparse-lane compaction into an empty queue
        set_group(1'b0, 4'b0000, 32'h0);
        dq.i_deq_ready = 1'b1;
        step();
        check("drain_count",   dq.o_count,   0);
        check("drain_deq_vld", dq.o_deq_vld, 0);
        dq.i_deq_ready = 1'b0;
        set_group(1'b1, 4'b1010, 32'h1FC);
        step();
        check("cmp_deq_vld", dq.o_deq_vld,       4'b0011);
        check("cmp_l0_pc",   dq.o_decinfo[0].pc, 32'h200);
        check("cmp_l1_pc",   dq.o_decinfo[1].pc, 32'h208);
        check("cmp_count",   dq.o_count,         2);

        // Partial dequeue of two entries
        set_group(1'b0, 4'b0000, 32'h0);
        dq.i_deq_ready = 1'b1;
        step();
        check("pdeq_count", dq.o_count, 0);
        dq.i_deq_ready = 1'b0;

        // Fill: four groups of four, crossing index 15 -> 0
        for (int g = 0; g < 4; g++) begin
            set_group(1'b1, 4'b1111, 32'h1000 + 32'(16 * g));
            step();
            if (g == 2) begin
                check("fill3_count",   dq.o_count,   12);
                check("fill3_can_enq", dq.o_can_enq, 1);
            end
        end
        check("full_count",   dq.o_count,         16);
        check("full_can_enq", dq.o_can_enq,       0);
        check("full_l0_pc",   dq.o_decinfo[0].pc, 32'h1000);

        // Enqueue while full is dropped
        set_group(1'b1, 4'b1111, 32'hBAD0);
        step();
        check("drop_count", dq.o_count,         16);
        check("drop_l0_pc", dq.o_decinfo[0].pc, 32'h1000);

        // Dequeue while full with enqueue held: enqueue still dropped
        dq.i_deq_ready = 1'b1;
        step();
        check("cfull_count",   dq.o_count,         12);
        check("cfull_can_enq", dq.o_can_enq,       1);
        check("cfull_l0_pc",   dq.o_decinfo[0].pc, 32'h1010);

        // Drain down to four entries
        set_group(1'b0, 4'b0000, 32'h0);
        step();
        step();
        check("pre_wrap_count", dq.o_count,         4);
        check("pre_wrap_l0_pc", dq.o_decinfo[0].pc, 32'h1030);

        // Sustained 4-in / 4-out with wrap-around
        exp_head = 32'h1030;
        next_in  = 32'h1040;
        for (int c = 0; c < 10; c++) begin
            set_group(1'b1, 4'b1111, next_in);
            step();
            exp_head = exp_head + 32'd16;
            next_in  = next_in + 32'd16;
            check("wrap_count", dq.o_count, 4);
            for (int k = 0; k < OUTPORT_NUM; k++) begin
                check("wrap_pc", dq.o_decinfo[k].pc, exp_head + 32'(4 * k));
            end
        end

        // Drain, then build count = 9
        set_group(1'b0, 4'b0000, 32'h0);
        step();
        check("drain2_count", dq.o_count, 0);
        dq.i_deq_ready = 1'b0;
        set_group(1'b1, 4'b1111, 32'h2000);
        step();
        set_group(1'b1, 4'b1111, 32'h2010);
        step();
        set_group(1'b1, 4'b0001, 32'h2020);
        step();
        check("presq_count", dq.o_count, 9);

        // Squash with simultaneous enqueue and dequeue
        dq.i_squash_vld = 1'b1;
        dq.i_deq_ready  = 1'b1;
        set_group(1'b1, 4'b1111, 32'h2100);
        step();
        check("sq_count",   dq.o_count,   0);
        check("sq_deq_vld", dq.o_deq_vld, 0);
        check("sq_can_enq", dq.o_can_enq, 1);
        dq.i_squash_vld = 1'b0;
        dq.i_deq_ready  = 1'b0;

        // Empty-mask enqueue is a no-op
        set_group(1'b1, 4'b0000, 32'h2200);
        step();
        check("nop_count", dq.o_count, 0);

        // Single high lane lands at lane 0 after squash
        set_group(1'b1, 4'b0100, 32'h2FF8);
        step();
        check("post_sq_count",   dq.o_count,         1);
        check("post_sq_deq_vld", dq.o_deq_vld,       4'b0001);
        check("post_sq_l0_pc",   dq.o_decinfo[0].pc, 32'h3000);

        // Reset mid-operation
        set_group(1'b1, 4'b1111, 32'h4000);
        step();
        check("prerst_count", dq.o_count, 5);
        set_group(1'b1, 4'b1111, 32'h5000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count",   dq.o_count,   0);
        check("arst_deq_vld", dq.o_deq_vld, 0);
        check("arst_can_enq", dq.o_can_enq, 1);
        rst = 1'b0;
        step();
        check("postrst_count",   dq.o_count,      4);
        check("postrst_l0_info", dq.o_decinfo[0], make_info(32'h5000));
        check("postrst_l3_pc",   dq.o_decinfo[3].pc, 32'h500C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
